// File: rtl/btb_set_assoc_pkg.sv
// Branch-predictor shared definitions: counter state type, saturating counter
// helpers and the default BTB geometry.
package bp_pkg;

  localparam int unsigned BP_STATE_W = 4;
  typedef logic [BP_STATE_W-1:0] bp_state_t;

  localparam int unsigned BTB_ENTRIES = 16;
  localparam int unsigned BTB_WAYS    = 2;

  // Index width for n items; 0 when there is only one item to select.
  function automatic int unsigned idx_bits(int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  localparam int unsigned BTB_SETS  = BTB_ENTRIES / BTB_WAYS;
  localparam int unsigned BTB_IDX_W = idx_bits(BTB_SETS);

  function automatic bp_state_t ctr_max(int unsigned bits);
    return bp_state_t'((1 << bits) - 1);
  endfunction

  function automatic bp_state_t sat_inc(bp_state_t v, int unsigned bits);
    return (v >= ctr_max(bits)) ? ctr_max(bits) : v + 1'b1;
  endfunction

  function automatic bp_state_t sat_dec(bp_state_t v, int unsigned bits);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic bp_state_t weak_taken(int unsigned bits);
    return bp_state_t'(1 << (bits - 1));
  endfunction

endpackage

// File: rtl/btb_set_assoc_sat_counter.sv
// Next-state logic for one CTR_BITS-wide saturating direction counter.
module sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                taken_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  always_comb begin
    ctr_o = taken_i ? CTR_BITS'(sat_inc(bp_state_t'(ctr_i), CTR_BITS))
                    : CTR_BITS'(sat_dec(bp_state_t'(ctr_i), CTR_BITS));
  end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative BTB: combinational fetch lookup, EX-stage update/allocate on
// the clock edge with round-robin replacement, and whole-table flush.
module btb_set_assoc
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = BTB_ENTRIES,
  parameter int unsigned WAYS     = BTB_WAYS,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned PC_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_W-1:0]     fetch_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_W-1:0]     pred_target,
  output logic [CTR_BITS-1:0] pred_state,
  input  logic                upd_valid,
  input  logic [PC_W-1:0]     upd_pc,
  input  logic                upd_taken,
  input  logic [PC_W-1:0]     upd_target,
  input  logic                flush
);

  localparam int unsigned SETS  = ENTRIES / WAYS;
  localparam int unsigned IDX   = idx_bits(SETS);
  localparam int unsigned IDX_W = (IDX > 0) ? IDX : 1;
  localparam int unsigned WAY_W = (WAYS > 1) ? idx_bits(WAYS) : 1;
  localparam int unsigned TAG   = PC_W - 2 - IDX;

  typedef struct packed {
    logic                valid;
    logic [TAG-1:0]      tag;
    logic [PC_W-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t           tbl_q  [SETS][WAYS];
  entry_t           tbl_d  [SETS][WAYS];
  logic [WAY_W-1:0] vptr_q [SETS];
  logic [WAY_W-1:0] vptr_d [SETS];

  logic [IDX_W-1:0]    f_idx, u_idx;
  logic [TAG-1:0]      f_tag, u_tag;
  logic                f_hit, u_hit, u_full;
  logic [WAY_W-1:0]    f_way, u_way, u_inv_way, u_vic;
  logic [CTR_BITS-1:0] f_ctr, u_ctr, u_ctr_next;
  logic [PC_W-1:0]     f_target;
  logic [1:0]          unused_upd_pc_lsbs;

  assign unused_upd_pc_lsbs = upd_pc[1:0];

  always_comb begin
    f_tag = fetch_pc[PC_W-1:IDX+2];
    u_tag = upd_pc[PC_W-1:IDX+2];
  end

  // With a single set there is no index field at all.
  if (IDX > 0) begin : g_idx
    always_comb begin
      f_idx = fetch_pc[IDX+1:2];
      u_idx = upd_pc[IDX+1:2];
    end
  end else begin : g_no_idx
    always_comb begin
      f_idx = '0;
      u_idx = '0;
    end
  end

  // Fetch lookup; the ascending scan makes the lowest matching way win.
  always_comb begin
    f_hit = 1'b0;
    f_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!f_hit && tbl_q[f_idx][w].valid && tbl_q[f_idx][w].tag == f_tag) begin
        f_hit = 1'b1;
        f_way = WAY_W'(w);
      end
    end
    f_ctr       = tbl_q[f_idx][f_way].ctr;
    f_target    = tbl_q[f_idx][f_way].target;
    pred_hit    = f_hit;
    pred_taken  = f_hit && f_ctr[CTR_BITS-1];
    pred_target = f_hit ? f_target : fetch_pc + PC_W'(4);
    pred_state  = f_hit ? f_ctr : '0;
  end

  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    u_full    = 1'b1;
    u_inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!u_hit && tbl_q[u_idx][w].valid && tbl_q[u_idx][w].tag == u_tag) begin
        u_hit = 1'b1;
        u_way = WAY_W'(w);
      end
      if (u_full && !tbl_q[u_idx][w].valid) begin
        u_full    = 1'b0;
        u_inv_way = WAY_W'(w);
      end
    end
    u_vic = u_full ? vptr_q[u_idx] : u_inv_way;
    u_ctr = tbl_q[u_idx][u_way].ctr;
  end

  sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr_i   (u_ctr),
    .taken_i (upd_taken),
    .ctr_o   (u_ctr_next)
  );

  always_comb begin
    tbl_d  = tbl_q;
    vptr_d = vptr_q;
    if (flush) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        vptr_d[s] = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          tbl_d[s][w].valid = 1'b0;
        end
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        tbl_d[u_idx][u_way].ctr = u_ctr_next;
        if (upd_taken) begin
          tbl_d[u_idx][u_way].target = upd_target;
        end
      end else if (upd_taken) begin
        tbl_d[u_idx][u_vic].valid  = 1'b1;
        tbl_d[u_idx][u_vic].tag    = u_tag;
        tbl_d[u_idx][u_vic].target = upd_target;
        tbl_d[u_idx][u_vic].ctr    = CTR_BITS'(weak_taken(CTR_BITS));
        if (u_full) begin
          vptr_d[u_idx] = WAY_W'((32'(vptr_q[u_idx]) + 1) % WAYS);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        vptr_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          tbl_q[s][w] <= '0;
        end
      end
    end else begin
      tbl_q  <= tbl_d;
      vptr_q <= vptr_d;
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed bench for btb_set_assoc (ENTRIES=16, WAYS=2, CTR_BITS=2, PC_W=32).
module tb_btb_set_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_state;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;

  int n_tests = 0;
  int n_fail  = 0;

  btb_set_assoc #(
    .ENTRIES  (16),
    .WAYS     (2),
    .CTR_BITS (2),
    .PC_W     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_state  (pred_state),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic hit, input logic taken,
                               input logic [31:0] tgt, input logic [1:0] st);
    chk({tag, ".hit"},    32'(pred_hit),    32'(hit));
    chk({tag, ".taken"},  32'(pred_taken),  32'(taken));
    chk({tag, ".target"}, pred_target,      tgt);
    chk({tag, ".state"},  32'(pred_state),  32'(st));
  endtask

  // Present a lookup address and check the outputs at the next falling edge.
  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] tgt, input logic [1:0] st);
    fetch_pc = pc;
    @(negedge clk);
    check_outputs(tag, hit, taken, tgt, st);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    fetch_pc   = 32'h100;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    flush      = 1'b0;

    look("reset", 32'h100, 1'b0, 1'b0, 32'h104, 2'd0);
    rst = 1'b0;
    look("post_reset", 32'h40, 1'b0, 1'b0, 32'h44, 2'd0);

    // Allocate then train down; not-taken updates must not touch the target.
    upd(32'h40, 1'b1, 32'h80);
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h80, 2'd2);
    upd(32'h40, 1'b0, 32'h999);
    upd(32'h40, 1'b0, 32'h999);
    look("train_nt", 32'h40, 1'b1, 1'b0, 32'h80, 2'd0);

    for (int i = 0; i < 5; i++) upd(32'h40, 1'b1, 32'h84);
    look("sat_hi", 32'h40, 1'b1, 1'b1, 32'h84, 2'd3);
    upd(32'h40, 1'b0, 32'h0);
    look("sat_dec", 32'h40, 1'b1, 1'b1, 32'h84, 2'd2);

    // Set 0 conflicts: 0x60 fills way 1, 0x80 evicts way 0, 0xA0 evicts way 1.
    upd(32'h60, 1'b1, 32'h160);
    upd(32'h80, 1'b1, 32'h180);
    look("evict0.40", 32'h40, 1'b0, 1'b0, 32'h44, 2'd0);
    look("evict0.60", 32'h60, 1'b1, 1'b1, 32'h160, 2'd2);
    look("evict0.80", 32'h80, 1'b1, 1'b1, 32'h180, 2'd2);
    upd(32'hA0, 1'b1, 32'h1A0);
    look("evict1.60", 32'h60, 1'b0, 1'b0, 32'h64, 2'd0);
    look("evict1.80", 32'h80, 1'b1, 1'b1, 32'h180, 2'd2);
    look("evict1.A0", 32'hA0, 1'b1, 1'b1, 32'h1A0, 2'd2);

    upd(32'h44, 1'b0, 32'h500);
    look("miss_nt", 32'h44, 1'b0, 1'b0, 32'h48, 2'd0);

    flush = 1'b1;
    upd(32'h200, 1'b1, 32'h280);
    flush = 1'b0;
    look("flush.200", 32'h200, 1'b0, 1'b0, 32'h204, 2'd0);
    look("flush.80",  32'h80,  1'b0, 1'b0, 32'h84,  2'd0);
    look("flush.A0",  32'hA0,  1'b0, 1'b0, 32'hA4,  2'd0);
    upd(32'h40, 1'b1, 32'h90);
    look("realloc", 32'h40, 1'b1, 1'b1, 32'h90, 2'd2);

    // Lookup and allocating update of the same pc in one cycle.
    @(posedge clk);
    #1;
    fetch_pc   = 32'h300;
    upd_valid  = 1'b1;
    upd_pc     = 32'h300;
    upd_taken  = 1'b1;
    upd_target = 32'h3F0;
    @(negedge clk);
    check_outputs("rw_same", 1'b0, 1'b0, 32'h304, 2'd0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    check_outputs("rw_next", 1'b1, 1'b1, 32'h3F0, 2'd2);

    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 2'd0);

    // Asynchronous reset away from any clock edge.
    fetch_pc = 32'h300;
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 1'b0, 32'h304, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    look("after_rst", 32'h40, 1'b0, 1'b0, 32'h44, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_set_assoc.md
# btb_set_assoc

Parametrised set-associative branch target buffer with per-entry saturating direction counters, replacing the single-entry predictor in the fetch stage. A fetch-stage lookup returns the predicted direction, the target and the counter state in the same cycle. The counter state is carried down the pipe as `bp_state`. Resolved branches from EX update or allocate entries on the clock edge; a flush input invalidates the whole table.

## Interface
Parameters:
- `ENTRIES`, 16: total entries; power of two, at least `WAYS`.
- `WAYS`, 2: associativity; one of 1, 2, 4.
- `CTR_BITS`, 2: direction counter width; 1..4.
- `PC_W`, 32: PC width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_pc` in PC_W: IF-stage lookup address.
- `pred_hit` out 1: valid tag match in the indexed set.
- `pred_taken` out 1: `pred_hit` and counter MSB.
- `pred_target` out PC_W: stored target on hit, otherwise `fetch_pc+4`.
- `pred_state` out CTR_BITS: counter of the hit way; 0 on miss.
- `upd_valid` in 1: a resolved conditional branch is presented this cycle.
- `upd_pc` in PC_W: PC of the resolved branch.
- `upd_taken` in 1: actual outcome.
- `upd_target` in PC_W: actual target.
- `flush` in 1: invalidate all entries.

## Operation
- Derived sizes: SETS = ENTRIES/WAYS; IDX = log2(SETS), 0 when SETS = 1; TAG = PC_W-2-IDX.
- Index field is pc[IDX+1:2]; tag field is pc[PC_W-1:IDX+2]; pc[1:0] is ignored.
- Entry fields: `valid`, `tag`, `target`, `ctr`. Each set also holds a round-robin victim pointer of log2(WAYS) bits.
- Lookup is purely combinational from `fetch_pc` and registered table state.
  - A way hits when its entry is valid and its tag equals the lookup tag.
  - If more than one way hits, which is illegal, the lowest way number wins.
- Update on a rising edge when `upd_valid`=1 and `flush`=0:
  - Hit in the set of `upd_pc`:
    - Saturating counter increment when taken, decrement when not taken.
    - Counter clamps at 2^CTR_BITS-1 and at 0.
    - `target` is overwritten only when taken.
    - Victim pointer unchanged.
  - Miss and taken: allocate.
    - Victim is the lowest-numbered invalid way; if all ways are valid, the way at the victim pointer.
    - Write `valid`=1, the tag, `upd_target`, and `ctr` = 2^(CTR_BITS-1) (weakly taken).
    - Advance the victim pointer modulo WAYS only when all ways were valid.
  - Miss and not taken: no state change.
- `flush`=1 on an edge clears every `valid` and every victim pointer. Counters and targets are left as they are. `flush` has priority over `upd_valid` in the same cycle.
- Reset clears all `valid`, `ctr`, `target`, `tag` and victim pointers to 0.

## Timing
- Prediction latency is 0 cycles: outputs settle combinationally from `fetch_pc`.
- An update is visible to lookups from the cycle after its clock edge. There is no write-to-read bypass.
  - If `fetch_pc` and `upd_pc` match in the same cycle, the lookup returns the pre-update contents.
- Outputs while `rst`=1 or directly after reset, for any `fetch_pc`:
  - `pred_hit`=0, `pred_taken`=0, `pred_state`=0.
  - `pred_target` = `fetch_pc`+4.
- Reset asserted mid-operation clears the table immediately, without waiting for a clock edge. An update that coincides with reset assertion is lost.
- `pred_target` arithmetic is modulo 2^PC_W; `fetch_pc` = 0xFFFFFFFC gives 0x00000000.
- Counter behaviour with CTR_BITS=1: allocation writes 1; the counter acts as a last-outcome bit.
- WAYS = ENTRIES gives fully associative operation: IDX=0 and a single set.

## Structure
- `bp_pkg` (shared with the pipeline's `if_id` struct) holds:
  - a `bp_state_t` width constant;
  - `sat_inc`/`sat_dec` functions;
  - `weak_taken(CTR_BITS)` function;
  - `clog2`-derived localparams.
- The entry struct is declared locally in the module, because its field widths depend on parameters.
- Sub-module `sat_counter`: parametrised CTR_BITS next-state logic (inc/dec/clamp). It is instantiated per update path, not per entry.

## Test plan
- **Reset:** `rst`=1, `fetch_pc`=0x100 -> `pred_hit`=0, `pred_taken`=0, `pred_target`=0x104, `pred_state`=0.
- **Allocate and train:**
  - Update pc=0x40, taken, target=0x80 -> next cycle lookup at 0x40 gives hit=1, taken=1, target=0x80, state=2.
  - Two not-taken updates -> state=0, taken=0, hit=1.
- **Saturation:** five taken updates on pc=0x40 -> state stays at 3; one not-taken -> state=2, `pred_taken` still 1.
- **Replacement** (ENTRIES=16, WAYS=2; pcs 0x40, 0x60 and 0x80 share set 0):
  - Allocate 0x40, 0x60, then 0x80 -> 0x80 evicts way 0 (0x40 misses, 0x60 hits).
  - A fourth conflicting pc, 0xA0, evicts way 1 (0x60).
- **Flush priority:** `flush`=1 and a taken update of 0x200 in the same cycle -> next cycle all lookups miss, including 0x200.
- **Same-cycle read/write:** `fetch_pc`=`upd_pc`=0x300 on the allocating edge -> `pred_hit`=0 that cycle, 1 the next cycle.
